// File: rtl/regfile_sb_pkg.sv
// Shared defaults for the scoreboarded register file and its read ports.
package regfile_sb_pkg;

    localparam int DATA_W_DEF   = 64;
    localparam int ADDR_W_DEF   = 5;
    localparam int NUM_RD_DEF   = 2;
    localparam int ZERO_REG_DEF = 31;
    localparam int BYPASS_DEF   = 1;
    localparam int DEPTH        = 2 ** ADDR_W_DEF;

endpackage

// File: rtl/regfile_sb_rdport.sv
// One combinational read port: zero-register, write-bypass and busy masking.
module regfile_sb_rdport #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31,
    parameter int BYPASS   = 1
) (
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_busy,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_busy
);

    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);
    localparam bit                BYP_ON   = (BYPASS != 0);

    logic is_zero;
    logic fwd_hit;

    assign is_zero = (rd_addr == ZERO_IDX);
    assign fwd_hit = BYP_ON && wr_en && (wr_addr == rd_addr);

    always_comb begin
        rd_data = mem_data;
        rd_busy = mem_busy;
        if (is_zero) begin
            rd_data = '0;
            rd_busy = 1'b0;
        end else if (fwd_hit) begin
            // The retiring result satisfies the hazard in the same cycle.
            rd_data = wr_data;
            rd_busy = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Register file with NUM_RD read ports, one write port and a busy scoreboard.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = NUM_RD_DEF,
    parameter int ZERO_REG = ZERO_REG_DEF,
    parameter int BYPASS   = BYPASS_DEF
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [NUM_RD*ADDR_W-1:0] RdAddr,
    output logic [NUM_RD*DATA_W-1:0] RdData,
    output logic [NUM_RD-1:0]        RdBusy,
    input  logic                     WrEn,
    input  logic [ADDR_W-1:0]        WrAddr,
    input  logic [DATA_W-1:0]        WrData,
    input  logic                     IssueEn,
    input  logic [ADDR_W-1:0]        IssueAddr,
    input  logic                     FlushBusy,
    output logic [ADDR_W:0]          BusyCount
);

    localparam int                NUM_REGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0]   mem_reg [NUM_REGS];
    logic [NUM_REGS-1:0] busy_reg;
    logic [NUM_REGS-1:0] busy_next;
    logic [ADDR_W:0]     count_reg;
    logic [ADDR_W:0]     count_next;
    logic                set_hit;
    logic                clr_hit;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (WrEn && (WrAddr != ZERO_IDX)) begin
            mem_reg[WrAddr] <= WrData;
        end
    end

    // Issue is applied after writeback so a new producer supersedes the retiring one.
    always_comb begin
        busy_next = busy_reg;
        if (FlushBusy) begin
            busy_next = '0;
        end else begin
            if (WrEn) begin
                busy_next[WrAddr] = 1'b0;
            end
            if (IssueEn) begin
                busy_next[IssueAddr] = 1'b1;
            end
            busy_next[ZERO_IDX] = 1'b0;
        end
    end

    always_comb begin
        set_hit = IssueEn && (IssueAddr != ZERO_IDX) && !busy_reg[IssueAddr];
        clr_hit = WrEn && (WrAddr != ZERO_IDX) && busy_reg[WrAddr]
                  && !(IssueEn && (IssueAddr == WrAddr));
        if (FlushBusy) begin
            count_next = '0;
        end else begin
            count_next = count_reg + (ADDR_W + 1)'(set_hit) - (ADDR_W + 1)'(clr_hit);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            busy_reg  <= '0;
            count_reg <= '0;
        end else begin
            busy_reg  <= busy_next;
            count_reg <= count_next;
        end
    end

    assign BusyCount = count_reg;

    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] addr;
            assign addr = RdAddr[gi*ADDR_W +: ADDR_W];

            regfile_sb_rdport #(
                .DATA_W   (DATA_W),
                .ADDR_W   (ADDR_W),
                .ZERO_REG (ZERO_REG),
                .BYPASS   (BYPASS)
            ) u_rdport (
                .rd_addr  (addr),
                .wr_en    (WrEn),
                .wr_addr  (WrAddr),
                .wr_data  (WrData),
                .mem_data (mem_reg[addr]),
                .mem_busy (busy_reg[addr]),
                .rd_data  (RdData[gi*DATA_W +: DATA_W]),
                .rd_busy  (RdBusy[gi])
            );
        end
    endgenerate

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised successor to the 32x64 datapath register file. It provides NUM_RD combinational read ports, one posedge write port with optional write-to-read bypass, and a hardwired zero register. It also keeps a per-register busy scoreboard, set at issue and cleared at writeback, so the pipeline control unit can detect RAW hazards on multi-cycle results (loads, multiply). It sits between decode (read/issue) and writeback.

Parameters:
DATA_W, 64, register width in bits
ADDR_W, 5, register index width; depth = 2**ADDR_W
NUM_RD, 2, number of independent read ports (>=1)
ZERO_REG, 31, index that always reads 0, is never written and is never busy
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports; 0 = no forwarding

Ports:
Clk  input  1  clock; all state updates on posedge
Reset  input  1  synchronous, active-high reset
RdAddr  input  NUM_RD*ADDR_W  read indices; port i = bits [i*ADDR_W +: ADDR_W]
RdData  output  NUM_RD*DATA_W  read data; port i = bits [i*DATA_W +: DATA_W]
RdBusy  output  NUM_RD  1 = port i operand is not yet valid (hazard)
WrEn  input  1  writeback strobe
WrAddr  input  ADDR_W  writeback index
WrData  input  DATA_W  writeback data
IssueEn  input  1  mark IssueAddr as having an outstanding producer
IssueAddr  input  ADDR_W  destination index of the issuing instruction
FlushBusy  input  1  clear the whole scoreboard (pipeline flush)
BusyCount  output  ADDR_W+1  registered count of busy registers

Behaviour:
- Reset (synchronous, dominates all other inputs): every register = 0, every busy bit = 0, BusyCount = 0. WrEn, IssueEn and FlushBusy are ignored in a Reset cycle. There is no X state after the first reset edge.
- Write: at posedge, if WrEn && WrAddr != ZERO_REG, then reg[WrAddr] <= WrData. A write to ZERO_REG is silently dropped.
- Read is combinational, with zero latency from RdAddr:
  - RdAddr[i] == ZERO_REG gives 0.
  - Otherwise, if BYPASS && WrEn && WrAddr == RdAddr[i], the port returns WrData.
  - Otherwise the port returns reg[RdAddr[i]].
  - Ports are independent; any ports may read the same index.
- Busy update at posedge, in priority order Reset > FlushBusy > per-index rules:
  - FlushBusy: all busy <= 0. Any IssueEn in the same cycle is ignored.
  - WrEn clears busy[WrAddr].
  - IssueEn sets busy[IssueAddr]. If IssueAddr == WrAddr in the same cycle, set wins (a new producer supersedes the retiring one).
  - ZERO_REG busy bit is tied to 0.
  - IssueEn on an already-busy index keeps it busy; there is no count of producers.
  - WrEn on a non-busy index writes data and leaves busy at 0.
- RdBusy[i] = busy[RdAddr[i]] && !(BYPASS && WrEn && WrAddr == RdAddr[i]). With BYPASS=0, a busy register reads busy until the cycle after its write.
- BusyCount: registered, equals popcount(busy) after each edge, range 0..2**ADDR_W-1. It is maintained incrementally (+1 on a 0->1 set, -1 on a 1->0 clear, net 0 when both happen) and reloaded to 0 on Reset or FlushBusy.

Decomposition:
- Shared package: DATA_W/ADDR_W defaults, ZERO_REG constant, localparam DEPTH = 2**ADDR_W.
- One natural sub-module: regfile_sb_rdport, a single read port containing the zero/bypass/busy mux. It is instantiated NUM_RD times via generate.
- Storage array and scoreboard stay in the top module.

Test Plan:
1. Reset high 1 cycle, then read all indices on both ports -> RdData = 0, RdBusy = 0, BusyCount = 0.
2. WrEn, WrAddr=5, WrData=64'hDEAD_BEEF, RdAddr0=5 in the same cycle -> BYPASS=1: RdData0 = DEADBEEF that cycle. BYPASS=0: old value that cycle, DEADBEEF next cycle.
3. WrEn, WrAddr=31, WrData=all ones; next cycle RdAddr1=31 -> RdData1 = 0. IssueEn to 31 -> BusyCount stays 0.
4. IssueEn to 7 -> next cycle RdBusy for index 7 = 1, BusyCount = 1. Later WrEn to 7 with 64'h1234 -> RdBusy = 0 in the write cycle (BYPASS=1) and RdData = 1234.
5. Same cycle IssueEn=7 and WrEn=7 while 7 is busy -> busy[7] stays 1, reg[7] updated, BusyCount unchanged.
6. Issue to 1, 2, 3 on consecutive cycles (BusyCount = 3), then FlushBusy together with IssueEn=4 -> all RdBusy = 0, BusyCount = 0. Assert Reset with WrEn=1 to index 9 -> reg[9] stays 0.
